mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Single-master controller for the shared external memory port (Addr/RD/WR/DataOut/DataIn).
- Arbitrates between four requesters: instruction fetch, scalar store, vector load and vector store.
- Sequences single-word transfers and BURST_LEN-word vector bursts.
- Packs vector-load words into a vector register image, and unpacks the vector-store image into words.

Parameters:
- BURST_LEN, 16: words per vector transfer.
- DATA_W, 16: memory word width.
- ADDR_W, 16: memory address width.
- Vector width VW = BURST_LEN*DATA_W (256 at defaults).

Ports:
Clk  in  1  Single clock, rising edge.
Reset_n  in  1  Asynchronous, active-low reset.
fetch_req  in  1  Request a single-word read.
fetch_addr  in  ADDR_W  Fetch address.
fetch_data  out  DATA_W  Fetched word; valid while fetch_done is high and held afterwards.
fetch_done  out  1  One-cycle completion pulse.
sst_req  in  1  Request a single-word write.
sst_addr  in  ADDR_W  Scalar store address.
sst_data  in  DATA_W  Scalar store data.
sst_done  out  1  One-cycle completion pulse.
vld_req  in  1  Request a burst read.
vld_addr  in  ADDR_W  Vector load base address.
vld_data  out  VW  Packed load image; word k sits at bits [DATA_W*k +: DATA_W].
vld_done  out  1  One-cycle completion pulse.
vst_req  in  1  Request a burst write.
vst_addr  in  ADDR_W  Vector store base address.
vst_data  in  VW  Store image, same packing as vld_data.
vst_done  out  1  One-cycle completion pulse.
Addr  out  ADDR_W  Memory address.
RD  out  1  Memory read strobe.
WR  out  1  Memory write strobe.
DataOut  out  DATA_W  Memory write data.
DataIn  in  DATA_W  Memory read data; valid the cycle after RD.
busy  out  1  High in any state other than IDLE.
owner  out  2  Current grant: 0 fetch, 1 sst, 2 vld, 3 vst.

Behaviour:
Reset and outputs
- All outputs are registered.
- Reset_n low clears every output to 0 asynchronously: Addr, RD, WR, DataOut, fetch_data, vld_data, all done pulses, busy, owner. The FSM returns to IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. RD and WR drop at reset assertion, and no done pulse is issued.

FSM states: IDLE, RD_ISSUE, RD_LAST, WR_ISSUE, DONE.

Arbitration (IDLE)
- Fixed, non-preemptive priority: sst > vst > vld > fetch.
- At the edge leaving IDLE, the winner's address is latched, owner is set, and the beat counter is cleared.
- Readers go to RD_ISSUE; writers go to WR_ISSUE.
- No request present: remain in IDLE.
- Beat count N = 1 for fetch and sst, BURST_LEN for vld and vst.

RD_ISSUE
- RD=1, Addr=base+beat (mod 2^ADDR_W, wraps).
- Runs N cycles, then goes to RD_LAST.

Read data capture
- DataIn for beat k is captured on the edge ending the cycle after beat k was issued. Issues are pipelined.
- RD_LAST: RD=0, captures the final beat, then goes to DONE.
- vld: word k is written into vld_data. Bits not yet received keep their previous value.
- fetch: the word is written into fetch_data.

WR_ISSUE
- WR=1, Addr=base+beat, DataOut = sst_data (sst) or vst_data word k (vst).
- Runs N cycles, then goes to DONE.
- sst_data and vst_data are sampled live. The requester holds them stable until done.

DONE
- The owner's done pulse is high for exactly one cycle. RD=0, WR=0.
- Next state is IDLE.
- The requester must deassert req by the edge ending the done cycle. A req still high in IDLE is treated as a new request.

Latency (req high in cycle 0)
- fetch: RD in cycle 1, fetch_done in cycle 3.
- sst: WR in cycle 1, sst_done in cycle 2.
- vld: RD in cycles 1..BURST_LEN, vld_done in cycle BURST_LEN+2.
- vst: WR in cycles 1..BURST_LEN, vst_done in cycle BURST_LEN+1.

Other rules
- Requests arriving during a transfer wait. Losing requests are held pending, not dropped.
- Address changes after grant are ignored.
- RD and WR are never high in the same cycle. At most one done pulse is high per cycle.
- Addr and DataOut hold their last values while idle.

Test Plan:
- fetch_req, fetch_addr=0x0040, memory returns 0xA5A5 -> RD=1 with Addr=0x0040 in cycle 1 only; fetch_done=1 in cycle 3; fetch_data=0xA5A5.
- sst_req, sst_addr=0x1234, sst_data=0xBEEF -> WR=1, Addr=0x1234, DataOut=0xBEEF in cycle 1; sst_done in cycle 2; RD stays 0 throughout.
- vld_req, vld_addr=0xFFF8, memory returns data=address -> Addr sequence 0xFFF8..0xFFFF, 0x0000..0x0007 (wrap); vld_done in cycle 18; vld_data word k = (0xFFF8+k) mod 2^16.
- vst_req, vst_addr=0x0100, vst_data words 0x0000..0x000F -> 16 consecutive WR cycles, Addr 0x0100..0x010F, DataOut=k; vst_done in cycle 17.
- fetch_req, vld_req and sst_req all high in the same cycle -> grant order sst, then vld, then fetch; owner=1, 2, 0; no two done pulses in the same cycle.
- vld in progress, Reset_n low at beat 5 -> RD, busy, owner go to 0 immediately; vld_data cleared; no vld_done; after release, FSM idles until the next request.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-master controller for the shared memory port.
// Arbitrates fetch/sst/vld/vst and sequences single and burst transfers.
module mem_bus_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        fetch_req,
    input  logic [ADDR_W-1:0]           fetch_addr,
    output logic [DATA_W-1:0]           fetch_data,
    output logic                        fetch_done,
    input  logic                        sst_req,
    input  logic [ADDR_W-1:0]           sst_addr,
    input  logic [DATA_W-1:0]           sst_data,
    output logic                        sst_done,
    input  logic                        vld_req,
    input  logic [ADDR_W-1:0]           vld_addr,
    output logic [BURST_LEN*DATA_W-1:0] vld_data,
    output logic                        vld_done,
    input  logic                        vst_req,
    input  logic [ADDR_W-1:0]           vst_addr,
    input  logic [BURST_LEN*DATA_W-1:0] vst_data,
    output logic                        vst_done,
    output logic [ADDR_W-1:0]           Addr,
    output logic                        RD,
    output logic                        WR,
    output logic [DATA_W-1:0]           DataOut,
    input  logic [DATA_W-1:0]           DataIn,
    output logic                        busy,
    output logic [1:0]                  owner
);
    localparam int VW = BURST_LEN * DATA_W;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_B = CW'(BURST_LEN - 1);
    localparam logic [1:0] OWN_FETCH = 2'd0;
    localparam logic [1:0] OWN_SST   = 2'd1;
    localparam logic [1:0] OWN_VLD   = 2'd2;
    localparam logic [1:0] OWN_VST   = 2'd3;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_LAST, WR_ISSUE, DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       beat_q, beat_d, cap_q, cap_d, last_q, last_d;
    logic [CW-1:0]       beat_nx;
    logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
    logic [1:0]          owner_q, owner_d;
    logic                rd_q, rd_d, wr_q, wr_d, rd_prev_q, rd_prev_d;
    logic [DATA_W-1:0]   dout_q, dout_d, fdata_q, fdata_d, vst_word;
    logic [VW-1:0]       vdata_q, vdata_d;
    logic                fdone_q, fdone_d, sdone_q, sdone_d;
    logic                vldone_q, vldone_d, vsdone_q, vsdone_d;
    logic                busy_q, busy_d;

    assign beat_nx = beat_q + CW'(1);

    always_comb begin
        vst_word = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (beat_nx == CW'(k)) vst_word = vst_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cap_d     = cap_q;
        last_d    = last_q;
        base_d    = base_q;
        addr_d    = addr_q;
        owner_d   = owner_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        rd_prev_d = rd_q;
        dout_d    = dout_q;
        fdata_d   = fdata_q;
        vdata_d   = vdata_q;
        fdone_d   = 1'b0;
        sdone_d   = 1'b0;
        vldone_d  = 1'b0;
        vsdone_d  = 1'b0;

        // Read data lands one cycle behind its RD strobe.
        if (rd_prev_q) begin
            if (owner_q[1]) begin
                for (int k = 0; k < BURST_LEN; k++) begin
                    if (cap_q == CW'(k)) vdata_d[k*DATA_W +: DATA_W] = DataIn;
                end
            end else begin
                fdata_d = DataIn;
            end
            cap_d = cap_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (sst_req || vst_req || vld_req || fetch_req) begin
                    if (sst_req) begin
                        owner_d = OWN_SST;
                        addr_d  = sst_addr;
                    end else if (vst_req) begin
                        owner_d = OWN_VST;
                        addr_d  = vst_addr;
                    end else if (vld_req) begin
                        owner_d = OWN_VLD;
                        addr_d  = vld_addr;
                    end else begin
                        owner_d = OWN_FETCH;
                        addr_d  = fetch_addr;
                    end
                    base_d = addr_d;
                    beat_d = '0;
                    cap_d  = '0;
                    last_d = owner_d[1] ? LAST_B : '0;
                    // Odd owner codes are the writers.
                    if (owner_d[0]) begin
                        state_d = WR_ISSUE;
                        wr_d    = 1'b1;
                        dout_d  = owner_d[1] ? vst_data[DATA_W-1:0] : sst_data;
                    end else begin
                        state_d = RD_ISSUE;
                        rd_d    = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                if (beat_q == last_q) begin
                    state_d = RD_LAST;
                end else begin
                    beat_d = beat_nx;
                    addr_d = base_q + ADDR_W'(beat_nx);
                    rd_d   = 1'b1;
                end
            end
            RD_LAST: begin
                state_d = DONE;
                if (owner_q[1]) vldone_d = 1'b1;
                else            fdone_d  = 1'b1;
            end
            WR_ISSUE: begin
                if (beat_q == last_q) begin
                    state_d = DONE;
                    if (owner_q[1]) vsdone_d = 1'b1;
                    else            sdone_d  = 1'b1;
                end else begin
                    beat_d = beat_nx;
                    addr_d = base_q + ADDR_W'(beat_nx);
                    dout_d = vst_word;
                    wr_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            cap_q     <= '0;
            last_q    <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            owner_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_prev_q <= 1'b0;
            dout_q    <= '0;
            fdata_q   <= '0;
            vdata_q   <= '0;
            fdone_q   <= 1'b0;
            sdone_q   <= 1'b0;
            vldone_q  <= 1'b0;
            vsdone_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cap_q     <= cap_d;
            last_q    <= last_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            owner_q   <= owner_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_prev_q <= rd_prev_d;
            dout_q    <= dout_d;
            fdata_q   <= fdata_d;
            vdata_q   <= vdata_d;
            fdone_q   <= fdone_d;
            sdone_q   <= sdone_d;
            vldone_q  <= vldone_d;
            vsdone_q  <= vsdone_d;
            busy_q    <= busy_d;
        end
    end

    assign Addr       = addr_q;
    assign RD         = rd_q;
    assign WR         = wr_q;
    assign DataOut    = dout_q;
    assign fetch_data = fdata_q;
    assign vld_data   = vdata_q;
    assign fetch_done = fdone_q;
    assign sst_done   = sdone_q;
    assign vld_done   = vldone_q;
    assign vst_done   = vsdone_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter
// against a transaction-timeline model kept in the bench.
module tb_mem_bus_arbiter;
    localparam int BL = 16;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int VW = BL * DW;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          fetch_req = 0, sst_req = 0, vld_req = 0, vst_req = 0;
    logic [AW-1:0] fetch_addr = 0, sst_addr = 0, vld_addr = 0, vst_addr = 0;
    logic [DW-1:0] sst_data = 0;
    logic [VW-1:0] vst_data = 0;
    logic [DW-1:0] DataIn = 0;
    logic [DW-1:0] fetch_data, DataOut;
    logic [VW-1:0] vld_data;
    logic          fetch_done, sst_done, vld_done, vst_done;
    logic [AW-1:0] Addr;
    logic          RD, WR, busy;
    logic [1:0]    owner;

    mem_bus_arbiter #(.BURST_LEN(BL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_done(fetch_done),
        .sst_req(sst_req), .sst_addr(sst_addr),
        .sst_data(sst_data), .sst_done(sst_done),
        .vld_req(vld_req), .vld_addr(vld_addr),
        .vld_data(vld_data), .vld_done(vld_done),
        .vst_req(vst_req), .vst_addr(vst_addr),
        .vst_data(vst_data), .vst_done(vst_done),
        .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut),
        .DataIn(DataIn), .busy(busy), .owner(owner)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    // expected outputs for the current cycle
    logic [AW-1:0] e_addr = 0;
    logic          e_rd = 0, e_wr = 0, e_busy = 0;
    logic [DW-1:0] e_dout = 0, e_fdata = 0;
    logic [VW-1:0] e_vdata = 0;
    logic          e_fdone = 0, e_sdone = 0, e_vldone = 0, e_vsdone = 0;
    logic [1:0]    e_owner = 0;

    // transaction model
    bit            m_act = 0, m_fin = 0, m_wr = 0;
    int            m_own = 0, m_n = 0, m_t = 0;
    logic [AW-1:0] m_base = 0;

    // memory model: word at address a is a ^ salt
    logic [DW-1:0] salt = 0;
    logic          prev_rd = 0;
    logic [AW-1:0] prev_addr = 0;
    bit            rnd_en = 0;

    task automatic chk(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        e_addr = 0; e_rd = 0; e_wr = 0; e_busy = 0; e_dout = 0;
        e_fdata = 0; e_vdata = 0; e_owner = 0;
        e_fdone = 0; e_sdone = 0; e_vldone = 0; e_vsdone = 0;
        m_act = 0; m_fin = 0; m_t = 0;
        prev_rd = 0;
    endtask

    task automatic tick_a();
        bit dr[4];
        dr = '{default: 0};
        @(negedge Clk);
        chk("Addr", 256'(Addr), 256'(e_addr));
        chk("RD", 256'(RD), 256'(e_rd));
        chk("WR", 256'(WR), 256'(e_wr));
        chk("DataOut", 256'(DataOut), 256'(e_dout));
        chk("fetch_data", 256'(fetch_data), 256'(e_fdata));
        chk("vld_data", vld_data, e_vdata);
        chk("fetch_done", 256'(fetch_done), 256'(e_fdone));
        chk("sst_done", 256'(sst_done), 256'(e_sdone));
        chk("vld_done", 256'(vld_done), 256'(e_vldone));
        chk("vst_done", 256'(vst_done), 256'(e_vsdone));
        chk("busy", 256'(busy), 256'(e_busy));
        chk("owner", 256'(owner), 256'(e_owner));
        chk("rd_wr_excl", 256'(RD & WR), 256'(0));
        chk("one_done", 256'($countones({fetch_done, sst_done,
            vld_done, vst_done}) <= 1), 256'(1));
        if (e_fdone)  begin fetch_req = 0; dr[0] = 1; end
        if (e_sdone)  begin sst_req = 0;   dr[1] = 1; end
        if (e_vldone) begin vld_req = 0;   dr[2] = 1; end
        if (e_vsdone) begin vst_req = 0;   dr[3] = 1; end
        if (rnd_en) begin
            if (!fetch_req && !dr[0] && $urandom_range(0, 5) == 0) begin
                fetch_req = 1; fetch_addr = AW'($urandom);
            end
            if (!sst_req && !dr[1] && $urandom_range(0, 7) == 0) begin
                sst_req = 1; sst_addr = AW'($urandom);
                sst_data = DW'($urandom);
            end
            if (!vld_req && !dr[2] && $urandom_range(0, 9) == 0) begin
                vld_req = 1; vld_addr = AW'($urandom);
            end
            if (!vst_req && !dr[3] && $urandom_range(0, 9) == 0) begin
                vst_req = 1; vst_addr = AW'($urandom);
                for (int i = 0; i < VW / 32; i++)
                    vst_data[i*32 +: 32] = $urandom;
            end
            // post-grant address changes must be ignored
            if (m_act && $urandom_range(0, 1) == 0) begin
                case (m_own)
                    0: fetch_addr = AW'($urandom);
                    1: sst_addr   = AW'($urandom);
                    2: vld_addr   = AW'($urandom);
                    default: vst_addr = AW'($urandom);
                endcase
            end
        end
    endtask

    task automatic tick_b();
        int k;
        DataIn = prev_rd ? (prev_addr ^ salt) : DW'($urandom);
        prev_rd = RD;
        prev_addr = Addr;
        e_rd = 0; e_wr = 0;
        e_fdone = 0; e_sdone = 0; e_vldone = 0; e_vsdone = 0;
        if (m_fin) begin
            m_act = 0; m_fin = 0; e_busy = 0;
        end else begin
            if (!m_act && (sst_req || vst_req || vld_req || fetch_req)) begin
                if (sst_req)      begin m_own = 1; m_base = sst_addr; end
                else if (vst_req) begin m_own = 3; m_base = vst_addr; end
                else if (vld_req) begin m_own = 2; m_base = vld_addr; end
                else              begin m_own = 0; m_base = fetch_addr; end
                m_act = 1; m_t = 0;
                m_n = (m_own >= 2) ? BL : 1;
                m_wr = (m_own == 1) || (m_own == 3);
                e_owner = 2'(m_own);
            end
            if (m_act) begin
                m_t++;
                e_busy = 1;
                if (m_t <= m_n) e_addr = m_base + AW'(m_t - 1);
                if (!m_wr) begin
                    if (m_t <= m_n) e_rd = 1;
                    if (m_t >= 3 && m_t - 3 < m_n) begin
                        k = m_t - 3;
                        if (m_own == 0) e_fdata = (m_base + AW'(k)) ^ salt;
                        else e_vdata[k*DW +: DW] = (m_base + AW'(k)) ^ salt;
                    end
                    if (m_t == m_n + 2) begin
                        m_fin = 1;
                        if (m_own == 0) e_fdone = 1; else e_vldone = 1;
                    end
                end else begin
                    if (m_t <= m_n) begin
                        e_wr = 1;
                        e_dout = (m_own == 1) ? sst_data
                                              : vst_data[(m_t-1)*DW +: DW];
                    end
                    if (m_t == m_n + 1) begin
                        m_fin = 1;
                        if (m_own == 1) e_sdone = 1; else e_vsdone = 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        tick_a();
        tick_b();
    endtask

    task automatic run_one(input int who, input logic [AW-1:0] a,
                           input logic [VW-1:0] d, input int exp_lat,
                           input int exp_beats, input string nm);
        int lat = -1;
        int beats = 0;
        bit dn;
        tick_a();
        case (who)
            0: begin fetch_req = 1; fetch_addr = a; end
            1: begin sst_req = 1; sst_addr = a; sst_data = d[DW-1:0]; end
            2: begin vld_req = 1; vld_addr = a; end
            default: begin vst_req = 1; vst_addr = a; vst_data = d; end
        endcase
        tick_b();
        for (int k = 1; k <= 40; k++) begin
            tick_a();
            if (RD || WR) beats++;
            case (who)
                0: dn = fetch_done;
                1: dn = sst_done;
                2: dn = vld_done;
                default: dn = vst_done;
            endcase
            if (dn) lat = k;
            tick_b();
            if (lat >= 0) break;
        end
        chk({nm, "_latency"}, 256'(lat), 256'(exp_lat));
        chk({nm, "_beats"}, 256'(beats), 256'(exp_beats));
        chk({nm, "_owner"}, 256'(owner), 256'(who));
    endtask

    initial begin
        logic [VW-1:0] img;
        int ord[$];
        int own_q[$];
        bit found;

        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_RD", 256'(RD), 256'(0));
        chk("rst_owner", 256'(owner), 256'(0));
        chk("rst_Addr", 256'(Addr), 256'(0));
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1;
        tick_b();
        repeat (3) cycle();

        salt = 16'h0040 ^ 16'hA5A5;
        run_one(0, 16'h0040, '0, 3, 1, "fetch");
        chk("fetch_word", 256'(fetch_data), 256'(16'hA5A5));
        cycle();

        run_one(1, 16'h1234, 256'(16'hBEEF), 2, 1, "sst");
        chk("sst_addr", 256'(Addr), 256'(16'h1234));
        chk("sst_dout", 256'(DataOut), 256'(16'hBEEF));
        cycle();

        salt = 16'h0000;
        run_one(2, 16'hFFF8, '0, 18, 16, "vld");
        chk("vld_w0", 256'(vld_data[0*DW +: DW]), 256'(16'hFFF8));
        chk("vld_w7", 256'(vld_data[7*DW +: DW]), 256'(16'hFFFF));
        chk("vld_w8", 256'(vld_data[8*DW +: DW]), 256'(16'h0000));
        chk("vld_w15", 256'(vld_data[15*DW +: DW]), 256'(16'h0007));
        chk("vld_last_addr", 256'(Addr), 256'(16'h0007));
        cycle();

        img = '0;
        for (int k = 0; k < BL; k++) img[k*DW +: DW] = DW'(k);
        run_one(3, 16'h0100, img, 17, 16, "vst");
        chk("vst_last_addr", 256'(Addr), 256'(16'h010F));
        chk("vst_last_dout", 256'(DataOut), 256'(16'h000F));
        cycle();

        // simultaneous requests
        tick_a();
        fetch_req = 1; fetch_addr = 16'h0200;
        vld_req = 1;   vld_addr = 16'h0300;
        sst_req = 1;   sst_addr = 16'h0400; sst_data = 16'h1111;
        tick_b();
        for (int k = 0; k < 80; k++) begin
            tick_a();
            if (sst_done)   begin ord.push_back(1); own_q.push_back(int'(owner)); end
            if (vld_done)   begin ord.push_back(2); own_q.push_back(int'(owner)); end
            if (fetch_done) begin ord.push_back(0); own_q.push_back(int'(owner)); end
            tick_b();
            if (ord.size() >= 3) break;
        end
        chk("grant_count", 256'(ord.size()), 256'(3));
        if (ord.size() >= 3) begin
            chk("grant_1st", 256'(ord[0]), 256'(1));
            chk("grant_2nd", 256'(ord[1]), 256'(2));
            chk("grant_3rd", 256'(ord[2]), 256'(0));
            chk("owner_1st", 256'(own_q[0]), 256'(1));
            chk("owner_2nd", 256'(own_q[1]), 256'(2));
            chk("owner_3rd", 256'(own_q[2]), 256'(0));
        end
        cycle();

        // reset in the middle of a vector load
        found = 0;
        tick_a();
        vld_req = 1; vld_addr = 16'h0300;
        tick_b();
        for (int k = 0; k < 30; k++) begin
            tick_a();
            if (m_act && m_t == 6) begin
                found = 1;
                break;
            end
            tick_b();
        end
        chk("rst_beat5_found", 256'(found), 256'(1));
        chk("rst_pre_addr", 256'(Addr), 256'(16'h0305));
        #2;
        Reset_n = 0;
        vld_req = 0;
        #1;
        chk("arst_RD", 256'(RD), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_owner", 256'(owner), 256'(0));
        chk("arst_vld_data", vld_data, '0);
        chk("arst_Addr", 256'(Addr), 256'(0));
        chk("arst_vld_done", 256'(vld_done), 256'(0));
        model_reset();
        tick_b();
        tick_a();
        Reset_n = 1;
        tick_b();
        repeat (5) cycle();

        salt = DW'($urandom);
        rnd_en = 1;
        repeat (3000) cycle();
        rnd_en = 0;
        repeat (120) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
